// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified memory macro.
// The arbiter takes the slave view; the CPU/memory side (or a bench) takes the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (DM) ports,
// one access at a time with fixed latency; DM has priority with bounded IF starvation.
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(MAX_WAIT);
  localparam logic [LW-1:0] LatInit   = LW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = DM owns the current access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          if_win, dm_win;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    if_win   = 1'b0;
    dm_win   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if_win = bus.if_req & (~bus.dm_req | (starve_q == StarveMax));
        dm_win = bus.dm_req & ~if_win;
        if (if_win || dm_win) begin
          state_d = StIssue;
          owner_d = dm_win;
          we_d    = dm_win & bus.dm_we;
          addr_d  = dm_win ? bus.dm_addr : bus.if_addr;
          wdata_d = dm_win ? bus.dm_wdata : wdata_q;
        end
        if (if_win) begin
          starve_d = '0;
        end else if (dm_win && bus.if_req && (starve_q != StarveMax)) begin
          starve_d = starve_q + 1'b1;
        end
      end
      StIssue: begin
        if (MEM_LAT == 1) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          lat_d   = LatInit;
        end
      end
      StWait: begin
        if (lat_q == LW'(1)) begin
          state_d = StDone;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
    end
  end

  // Grants are combinational, so mask them while reset is held.
  assign bus.if_gnt    = if_win & ~rst;
  assign bus.dm_gnt    = dm_win & ~rst;
  assign bus.mem_cs    = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_valid  = (state_q == StDone) & ~owner_q;
  assign bus.dm_valid  = (state_q == StDone) & owner_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
endmodule
